// File: rtl/control_unit.sv
// Hardwired Moore sequencer for a small load/store CPU: fetch (T0..T2),
// opcode-driven execute (T3..T7), memory wait states and a sticky HALT.
module control_unit #(
    parameter logic [4:0] ALU_ADD = 5'b00011,
    parameter logic [4:0] OP_HALT = 5'b11011
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        stop,
    input  logic [31:0] IR,
    input  logic        con,
    input  logic        mem_done,
    output logic [4:0]  alu_control,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Pout,
    output logic        Cout,
    output logic        ZLOout,
    output logic        MDROut,
    output logic        Pen,
    output logic        IncPC,
    output logic        IRen,
    output logic        MARen,
    output logic        MDRen,
    output logic        Yen,
    output logic        Zen,
    output logic        ConIn,
    output logic        Read,
    output logic        Write,
    output logic        Run,
    output logic        illegal
);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;

    typedef enum logic [3:0] {
        RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    state_t     state_q, state_d, boundary;
    logic       illegal_q, illegal_d;
    logic       br_taken_q, br_taken_d;
    logic [4:0] op;
    logic       is_alu, is_imm, is_mem, is_ld, is_st, is_br, is_nop, known;
    logic       unused_ir;

    assign op        = IR[31:27];
    assign unused_ir = ^IR[26:0];
    assign is_alu    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    assign is_imm    = (op == OP_ADDI) || (op == OP_LDI);
    assign is_ld     = (op == OP_LD);
    assign is_st     = (op == OP_ST);
    assign is_mem    = is_ld || is_st;
    assign is_br     = (op == OP_BR);
    assign is_nop    = (op == OP_NOP);
    assign known     = is_alu || is_imm || is_mem || is_br || is_nop;

    // Every path back to T0 is an instruction boundary, the only place stop is honoured.
    assign boundary  = stop ? HALT : T0;

    // NOTE: state, cause flag and branch decision share one clocked block with <=,
    // so every register updates on the same edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= RST;
            illegal_q  <= 1'b0;
            br_taken_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            illegal_q  <= illegal_d;
            br_taken_q <= br_taken_d;
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        illegal_d  = (state_q == HALT) ? illegal_q : 1'b0;
        br_taken_d = (state_q == T5) ? con : br_taken_q;
        case (state_q)
            RST: state_d = boundary;
            T0:  state_d = T1;
            T1:  state_d = mem_done ? T2 : T1;
            T2:  state_d = T3;
            T3: begin
                if (op == OP_HALT) begin
                    state_d = HALT;
                end else if (!known) begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end else if (is_nop) begin
                    state_d = boundary;
                end else begin
                    state_d = T4;
                end
            end
            T4:  state_d = T5;
            T5:  state_d = (is_mem || is_br) ? T6 : boundary;
            T6: begin
                if (is_ld)      state_d = mem_done ? T7 : T6;
                else if (is_st) state_d = T7;
                else            state_d = boundary;
            end
            T7: begin
                if (is_st) state_d = mem_done ? boundary : T7;
                else       state_d = boundary;
            end
            HALT:    state_d = HALT;
            default: state_d = RST;
        endcase
    end

    always_comb begin
        alu_control = 5'b00000;
        {Gra, Grb, Grc, Rin, Rout, BAout}    = '0;
        {Pout, Cout, ZLOout, MDROut}         = '0;
        {Pen, IncPC, IRen, MARen, MDRen}     = '0;
        {Yen, Zen, ConIn, Read, Write}       = '0;
        Run     = (state_q != RST) && (state_q != HALT);
        illegal = (state_q == HALT) && illegal_q;
        case (state_q)
            T0: {Pout, MARen, IncPC} = 3'b111;
            T1: {Read, MDRen}        = 2'b11;
            T2: {MDROut, IRen}       = 2'b11;
            T3: begin
                if (is_alu || op == OP_ADDI)   {Grb, Rout, Yen}   = 3'b111;
                else if (is_mem || op == OP_LDI) {Grb, BAout, Yen} = 3'b111;
                else if (is_br)                {Gra, Rout, ConIn} = 3'b111;
            end
            T4: begin
                if (is_alu) begin
                    {Grc, Rout, Zen} = 3'b111;
                    alu_control      = op;
                end else if (is_imm || is_mem) begin
                    {Cout, Zen} = 2'b11;
                    alu_control = ALU_ADD;
                end else if (is_br) begin
                    {Pout, Yen} = 2'b11;
                end
            end
            T5: begin
                if (is_alu || is_imm) begin
                    {ZLOout, Gra, Rin} = 3'b111;
                end else if (is_mem) begin
                    {ZLOout, MARen} = 2'b11;
                end else if (is_br) begin
                    {Cout, Zen} = 2'b11;
                    alu_control = ALU_ADD;
                end
            end
            T6: begin
                if (is_ld) begin
                    {Read, MDRen} = 2'b11;
                end else if (is_st) begin
                    {Gra, Rout, MDRen} = 3'b111;
                end else if (is_br) begin
                    ZLOout = 1'b1;
                    Pen    = br_taken_q;
                end
            end
            T7: begin
                if (is_ld)      {MDROut, Gra, Rin} = 3'b111;
                else if (is_st) Write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter ALU_ADD, default 5'b00011, alu_control code for address and branch-target addition.
REQ-002 Parameter OP_HALT, default 5'b11011, opcode that stops the sequencer.
REQ-003 clk  input  1  system clock; all state changes occur on the rising edge.
REQ-004 clr  input  1  reset; synchronous and active-high.
REQ-005 stop  input  1  halt request; sampled only at instruction boundaries.
REQ-006 IR  input  32  instruction register contents from the datapath; opcode is IR[31:27].
REQ-007 con  input  1  branch condition flip-flop output from the datapath.
REQ-008 mem_done  input  1  memory handshake; high for the cycle in which the current Read/Write completes.
REQ-009 alu_control  output  5  ALU operation select.
REQ-010 Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  register-file field selects and strobes.
REQ-011 Pout, Cout, ZLOout, MDROut  output  1 each  bus source strobes.
REQ-012 Pen, IncPC, IRen, MARen, MDRen, Yen, Zen, ConIn  output  1 each  register load enables.
REQ-013 Read, Write  output  1 each  memory strobes.
REQ-014 Run  output  1  high while the sequencer is executing.
REQ-015 illegal  output  1  high in HALT when the halt was caused by an undefined opcode.

Function
REQ-016 Moore machine; every output SHALL be decoded from the state register and IR only, with no combinational path from mem_done, stop or con.
REQ-017 States SHALL be RST, T0..T7 and HALT; every output not listed for a state SHALL be 0.
REQ-018 Fetch: T0 = Pout, MARen, IncPC; T1 = Read, MDRen; T2 = MDROut, IRen; T2 -> T3.
REQ-019 T1 SHALL hold Read and MDRen while mem_done=0 and SHALL advance to T2 in the cycle after mem_done=1; T6 of ld and T7 of st SHALL follow the same rule.
REQ-020 ALU ops add 00011, sub 00100, and 00101, or 00110: T3 = Grb, Rout, Yen; T4 = Grc, Rout, Zen, alu_control=IR[31:27]; T5 = ZLOout, Gra, Rin; then T0.
REQ-021 addi 01100: T3 = Grb, Rout, Yen; T4 = Cout, Zen, alu_control=ALU_ADD; T5 = ZLOout, Gra, Rin; then T0.
REQ-022 ldi 00001: as addi except T3 = Grb, BAout, Yen.
REQ-023 ld 00000: T3..T4 as ldi; T5 = ZLOout, MARen; T6 = Read, MDRen (wait per REQ-019); T7 = MDROut, Gra, Rin; then T0.
REQ-024 st 00010: T3..T5 as ld; T6 = Gra, Rout, MDRen; T7 = Write (wait per REQ-019); then T0.
REQ-025 br 10010: T3 = Gra, Rout, ConIn; T4 = Pout, Yen; T5 = Cout, Zen, alu_control=ALU_ADD; T6 = ZLOout, and Pen only if con=1; then T0.
REQ-026 nop 11010: T3 -> T0 with all outputs 0 in T3.
REQ-027 OP_HALT in T3 SHALL go to HALT with illegal=0; any other undefined opcode in T3 SHALL go to HALT with illegal=1.
REQ-028 On every transition that would enter T0, stop=1 SHALL redirect to HALT with illegal=0 and leave the in-flight instruction completed; stop SHALL be ignored mid-instruction.
REQ-029 HALT SHALL be absorbing: all strobes 0, Run=0; only clr exits.
REQ-030 Run SHALL be 1 in T0..T7 and 0 in RST and HALT.
REQ-031 IR SHALL be sampled only in T3..T7; the IR change produced by IRen in T2 SHALL NOT alter outputs in T0..T2.

Reset
REQ-032 clr=1 at a rising edge SHALL force RST from any state, including mid-wait in T1/T6/T7; Write or Read SHALL drop the following cycle.
REQ-033 In RST all outputs SHALL be 0, including alu_control=0, Run=0 and illegal=0; the first edge with clr=0 SHALL move RST -> T0.
REQ-034 clr SHALL take priority over stop and mem_done.

Verification
REQ-035 clr 2 cycles, mem_done=1 always, IR=add (00011) -> T0,T1,T2,T3,T4,T5 in 6 cycles; T4 alu_control=00011; T5 Gra=Rin=ZLOout=1.
REQ-036 ld with mem_done low for 3 cycles in T6 -> Read=MDRen=1 for 4 cycles, then T7 MDROut=Gra=Rin=1.
REQ-037 br with con=0 then con=1 -> Pen=0 in the first T6, Pen=1 in the second T6, both with ZLOout=1.
REQ-038 stop=1 asserted in T4 of sub -> T5 completes, next state HALT, Run=0, illegal=0, held 10 cycles.
REQ-039 IR opcode 11111 -> HALT with illegal=1; clr=1 -> RST with all outputs 0, then T0.
REQ-040 clr asserted during st T7 wait -> Write=0 on the next cycle, state RST.
